toggle_bank: RTL
================

TOGGLE_BANK -- requirements
Module: toggle_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent toggle channels (>=1).
REQ-002 Parameter CNT_W, default 4: width of each per-channel toggle counter (>=1).
REQ-003 Parameter RESET_VAL, default 0 (WIDTH bits): value of out during and after reset.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port resetn  input  1: asynchronous, active-low reset.
REQ-006 Port in  input  WIDTH: per-channel toggle request.
REQ-007 Port edge_mode  input  1: 0 = level mode, 1 = rising-edge mode; applies to all channels.
REQ-008 Port load  input  1: synchronous parallel load of out.
REQ-009 Port load_val  input  WIDTH: value written to out when load=1.
REQ-010 Port cnt_clr  input  1: synchronous clear of all toggle counters.
REQ-011 Port out  output  WIDTH: registered toggle state, one bit per channel.
REQ-012 Port toggled  output  WIDTH: registered one-cycle pulse per channel, set when that channel's out changed by toggle in the same edge.
REQ-013 Port cnt  output  WIDTH*CNT_W: per-channel toggle counts; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-014 Port cnt_sat  output  1: registered; high while any channel counter equals 2^CNT_W-1.

Function
REQ-015 Block SHALL hold a WIDTH-bit registered in_q, updated every clock from in regardless of load, cnt_clr or edge_mode.
REQ-016 Toggle request t[i] SHALL be in[i] when edge_mode=0, and in[i] & ~in_q[i] when edge_mode=1.
REQ-017 When load=0 and t[i]=1, out[i] SHALL invert at the next rising edge; t[i]=0 holds out[i].
REQ-018 Level mode: in[i] held high N cycles SHALL produce N inversions (divide-by-2 of clk on out[i]).
REQ-019 Edge mode: in[i] held high any number of cycles SHALL produce exactly one inversion.
REQ-020 When load=1, out SHALL take load_val at the next edge; toggle requests that cycle are discarded (no inversion, no count, toggled=0).
REQ-021 toggled[i] SHALL be 1 for exactly the cycle following an edge at which channel i inverted due to a toggle, else 0.
REQ-022 Each counter SHALL increment by 1 per toggle of its channel and saturate at 2^CNT_W-1 (no wrap).
REQ-023 cnt_clr=1 with no toggle on channel i SHALL set cnt[i] to 0; cnt_clr=1 with a toggle on channel i SHALL set cnt[i] to 1 (clear then count).
REQ-024 cnt_clr SHALL not affect out, in_q or toggled.
REQ-025 A change of edge_mode SHALL take effect on the same cycle; in_q tracking guarantees no spurious edge from the mode switch itself.
REQ-026 cnt_sat SHALL be recomputed from the registered counters (one cycle after the saturating edge).
REQ-027 Channels SHALL be fully independent; no cross-channel logic except shared controls and cnt_sat OR-reduction.

Reset
REQ-028 resetn=0 SHALL immediately force out=RESET_VAL, in_q=0, toggled=0, all cnt=0, cnt_sat=0, independent of clk.
REQ-029 Assertion of resetn mid-operation SHALL abandon any pending toggle or load; no state update on the edge coincident with reset.
REQ-030 After resetn rises, an in[i] already high in edge mode SHALL count as a rising edge on the first active clock (in_q resets to 0).

Verification (WIDTH=4, CNT_W=3, RESET_VAL=4'b0000, 10 ns clock)
REQ-031 Reset with in=4'b1111 held 5 cycles -> out=0000, cnt all 0, toggled=0000 throughout.
REQ-032 Level mode, in=4'b0001 for 3 cycles -> out[0] sequence 1,0,1; cnt[0]=3; toggled[0] high 3 cycles; other channels unchanged.
REQ-033 Edge mode, in=4'b0010 for 4 cycles then 0 then 1 for 1 cycle -> out[1] inverts twice (ends 0); cnt[1]=2.
REQ-034 Level mode, in=4'b0100 for 9 cycles -> cnt[2] saturates at 7 and stays 7; cnt_sat rises the cycle after cnt[2] reaches 7; out[2]=1 after 9 inversions.
REQ-035 load=1, load_val=4'b1010, in=4'b1111 same cycle -> out=1010, toggled=0000, counts unchanged; then cnt_clr=1 with in[3]=1 (level) -> cnt[3]=1, others 0.
REQ-036 resetn dropped asynchronously between clock edges with out=1010, cnt[3]=5 -> out=0000, cnt=0 before the next edge.

Source files
------------

// File: rtl/toggle_bank.sv
// Bank of independent toggle flip-flops with level/rising-edge request modes,
// parallel load, and saturating per-channel toggle counters.
module toggle_bank #(
  parameter int                 WIDTH     = 8,
  parameter int                 CNT_W     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       in,
  input  logic                   edge_mode,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       toggled,
  output logic [WIDTH*CNT_W-1:0] cnt,
  output logic                   cnt_sat
);

  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] tg;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic             sat_any;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + 1'b1;
  endfunction

  // Request decode and next-count computation; a load swallows all requests.
  always_comb begin
    tg      = load ? '0 : (edge_mode ? (in & ~in_q) : in);
    sat_any = 1'b0;
    cnt     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_clr ? '0 : cnt_q[i];
      if (tg[i]) cnt_d[i] = sat_inc(cnt_d[i]);
      if (&cnt_q[i]) sat_any = 1'b1;
      cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // Register stage: in_q tracks in unconditionally so mode switches see no false edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out     <= RESET_VAL;
      in_q    <= '0;
      toggled <= '0;
      cnt_q   <= '{default: '0};
      cnt_sat <= 1'b0;
    end else begin
      in_q    <= in;
      out     <= load ? load_val : (out ^ tg);
      toggled <= tg;
      cnt_q   <= cnt_d;
      cnt_sat <= sat_any;
    end
  end

endmodule
